// File: rtl/secure_memory_controller_pkg.sv
// Shared widths, FSM state type and AES byte helpers for the secure memory controller.
package secure_memory_controller_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 128;
  localparam int NONCE_W = 96;

  typedef enum logic [1:0] {
    IDLE,
    CRYPT,
    FINISH
  } state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/secure_memory_controller_aes128_core.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
module aes128_core
  import secure_memory_controller_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] block,
  output logic         done,
  output logic [127:0] result
);

  logic [127:0] st, rk, rk_next;
  logic [7:0]   rcon;
  logic [3:0]   round;
  logic         run;

  // Byte i of a block sits at bits [127-8i -: 8]; state column c holds bytes 4c..4c+3.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign rk_next = expand(rk, rcon);
  assign result  = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= '0;
      rk    <= '0;
      rcon  <= 8'h01;
      round <= 4'd0;
      run   <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      st    <= block ^ key;
      rk    <= key;
      rcon  <= 8'h01;
      round <= 4'd1;
      run   <= 1'b1;
      done  <= 1'b0;
    end else if (run) begin
      rk    <= rk_next;
      rcon  <= xtime(rcon);
      round <= round + 4'd1;
      // The final round has no MixColumns.
      if (round == 4'd10) begin
        st   <= sub_shift(st) ^ rk_next;
        run  <= 1'b0;
        done <= 1'b1;
      end else begin
        st <= mix(sub_shift(st)) ^ rk_next;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/secure_memory_controller.sv
// AES-128 CTR encrypted 256x128 store; plaintext in/out, ciphertext at rest.
module secure_memory_controller
  import secure_memory_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [127:0]       key_in,
  input  logic [NONCE_W-1:0] nonce_in,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_data_in,
  input  logic               cpu_write_en,
  input  logic               cpu_read_en,
  output logic [DATA_W-1:0]  cpu_data_out,
  output logic               busy
);

  state_t             state, next_state;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q, rd_q, ks;
  logic               wr_q, accept, aes_done;
  logic [DATA_W-1:0]  mem [256];

  assign accept = (state == IDLE) && (cpu_write_en || cpu_read_en);
  assign busy   = (state != IDLE);

  aes128_core u_aes (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .key    (key_in),
    .block  ({nonce_in, 24'h000000, cpu_addr}),
    .done   (aes_done),
    .result (ks)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CRYPT;
      CRYPT:   if (aes_done) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Write wins over read when both strobes arrive together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      cpu_data_out <= '0;
    end else begin
      if (accept) begin
        addr_q <= cpu_addr;
        data_q <= cpu_data_in;
        wr_q   <= cpu_write_en;
      end
      if (state == FINISH && !wr_q) cpu_data_out <= rd_q ^ ks;
    end
  end

  // No reset on the store so it maps onto block RAM and survives reset.
  always_ff @(posedge clk) begin
    if (state == FINISH && wr_q) mem[addr_q] <= data_q ^ ks;
    rd_q <= mem[addr_q];
  end

endmodule

// File: tb/tb_secure_memory_controller.sv
// Directed bench for secure_memory_controller with an independent AES-128 reference.
module tb_secure_memory_controller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic [95:0]  nonce_in;
  logic [7:0]   cpu_addr;
  logic [127:0] cpu_data_in;
  logic         cpu_write_en;
  logic         cpu_read_en;
  logic [127:0] cpu_data_out;
  logic         busy;

  secure_memory_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .nonce_in     (nonce_in),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_write_en (cpu_write_en),
    .cpu_read_en  (cpu_read_en),
    .cpu_data_out (cpu_data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [127:0] sb_q[$];
  logic [127:0] model_out;
  logic [7:0]   sbox_tb[256];

  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [95:0]  N1  = 96'hF0F1F2F3F4F5F6F7F8F9FAFB;
  localparam logic [95:0]  N2  = 96'h0123456789ABCDEF01234567;
  localparam logic [127:0] PT  = 128'hDEADBEEFCAFEF00D12345678ABCDEF01;
  localparam logic [127:0] D10 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D33 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] D20 = 128'h1111222233334444555566667777AAAA;
  localparam logic [127:0] D2X = 128'h99998888777766665555444433332222;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0] w[44];
    logic [7:0]  s[16], t[16];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tb[tmp[23:16]], sbox_tb[tmp[15:8]], sbox_tb[tmp[7:0]], sbox_tb[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row + 4*c] = sbox_tb[s[row + 4*((c + row) % 4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] ks(input logic [95:0] n, input logic [7:0] a);
    return aes_enc(K, {n, 24'h000000, a});
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; strobes may be re-pulsed during busy to check they are ignored.
  task automatic run_op(input bit we, input bit re, input logic [7:0] a, input logic [127:0] d,
                        input logic [95:0] n, input string tag, input int pulse_at);
    int cycles;
    @(negedge clk);
    cpu_write_en = we; cpu_read_en = re;
    cpu_addr = a; cpu_data_in = d; key_in = K; nonce_in = n;
    @(posedge clk); #1;
    cpu_write_en = 1'b0; cpu_read_en = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    nonce_in = {$urandom, $urandom, $urandom};
    cpu_addr = 8'($urandom);
    cpu_data_in = {$urandom, $urandom, $urandom, $urandom};
    check({tag, "_busy_rise"}, 128'(busy), 128'd1);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      if (cycles == pulse_at) begin
        cpu_write_en = 1'b1; cpu_read_en = 1'b1;
        cpu_addr = 8'h44; cpu_data_in = '1;
      end else begin
        cpu_write_en = 1'b0; cpu_read_en = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    cpu_write_en = 1'b0; cpu_read_en = 1'b0;
    check({tag, "_latency"}, 128'(cycles), 128'd12);
    if (re && !we) model_out = sb_q.pop_front();
    check({tag, "_data_out"}, cpu_data_out, model_out);
  endtask

  logic [127:0] saved44;

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_tb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    check("golden_fips197", aes_enc(K, 128'h3243f6a8885a308d313198a2e0370734),
          128'h3925841d02dc09fbdc118597196a0b32);

    rst_n = 1'b0; key_in = '0; nonce_in = '0; cpu_addr = '0; cpu_data_in = '0;
    cpu_write_en = 1'b0; cpu_read_en = 1'b0;
    model_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_data_out", cpu_data_out, 128'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(1'b1, 1'b0, 8'hA5, PT, N1, "wr_a5", -1);
    check("mem_a5_cipher", dut.mem[8'hA5], PT ^ ks(N1, 8'hA5));
    check("mem_a5_differs", 128'(dut.mem[8'hA5] !== PT), 128'd1);
    sb_q.push_back(PT);
    run_op(1'b0, 1'b1, 8'hA5, '0, N1, "rd_a5", -1);

    saved44 = dut.mem[8'h44];
    run_op(1'b1, 1'b0, 8'h33, D33, N1, "wr_33_pulse", 5);
    repeat (3) @(posedge clk);
    #1;
    check("no_queued_after_wr", 128'(busy), 128'd0);
    check("mem_44_untouched_wr", dut.mem[8'h44], saved44);
    sb_q.push_back(D33);
    run_op(1'b0, 1'b1, 8'h33, '0, N1, "rd_33_pulse", 7);
    repeat (3) @(posedge clk);
    #1;
    check("no_queued_after_rd", 128'(busy), 128'd0);
    check("mem_44_untouched_rd", dut.mem[8'h44], saved44);

    run_op(1'b1, 1'b1, 8'h10, D10, N1, "both_10", -1);
    sb_q.push_back(D10);
    run_op(1'b0, 1'b1, 8'h10, '0, N1, "rd_10", -1);

    run_op(1'b1, 1'b0, 8'h20, D20, N1, "wr_20", -1);
    @(negedge clk);
    cpu_write_en = 1'b1; cpu_addr = 8'h20; cpu_data_in = D2X; key_in = K; nonce_in = N1;
    @(posedge clk); #1;
    cpu_write_en = 1'b0;
    check("wr_20_abort_busy_rise", 128'(busy), 128'd1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_data_out", cpu_data_out, 128'd0);
    model_out = '0;
    @(negedge clk); rst_n = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("abort_mem_20", dut.mem[8'h20], D20 ^ ks(N1, 8'h20));
    sb_q.push_back(D20);
    run_op(1'b0, 1'b1, 8'h20, '0, N1, "rd_20", -1);

    sb_q.push_back(PT ^ ks(N1, 8'hA5) ^ ks(N2, 8'hA5));
    run_op(1'b0, 1'b1, 8'hA5, '0, N2, "rd_a5_n2", -1);
    check("nonce_mismatch_differs", 128'(cpu_data_out !== PT), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/secure_memory_controller.md
SECURE_MEMORY_CONTROLLER -- requirements
Module: secure_memory_controller

Interface
REQ-001 SHALL have no parameters; address width is fixed at 8 bits, data and key width at 128 bits, nonce width at 96 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 key_in  input  128  AES-128 key; sampled when a request is accepted.
REQ-005 nonce_in  input  96  CTR nonce; sampled when a request is accepted.
REQ-006 cpu_addr  input  8  word address into the 256-entry store; sampled at accept.
REQ-007 cpu_data_in  input  128  plaintext for a write; sampled at accept.
REQ-008 cpu_write_en  input  1  single-cycle write request strobe.
REQ-009 cpu_read_en  input  1  single-cycle read request strobe.
REQ-010 cpu_data_out  output  128  registered decrypted read data.
REQ-011 busy  output  1  high while an operation is in progress.

Function
REQ-012 SHALL contain an internal store of 256 words of 128 bits, holding ciphertext only.
REQ-013 Counter block SHALL be {nonce_in, 24'h000000, cpu_addr} (128 bits, nonce in the MSBs).
REQ-014 Keystream SHALL be AES-128 encryption (FIPS-197) of the counter block under key_in.
REQ-015 Write: the value stored at cpu_addr SHALL be cpu_data_in XOR keystream.
REQ-016 Read: cpu_data_out SHALL be the stored word at cpu_addr XOR keystream, so a read with the same key/nonce/address returns the original plaintext.
REQ-017 A request is accepted on a rising edge where busy=0 and a strobe is high; busy SHALL be 1 from that same edge.
REQ-018 If both strobes are high at accept, the write SHALL take priority and the read SHALL be dropped.
REQ-019 Strobes asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 FSM states SHALL be IDLE -> CRYPT (AES rounds) -> FINISH -> IDLE.
- IDLE on accept -> CRYPT.
- CRYPT after the last AES round -> FINISH.
- FINISH -> IDLE, deasserting busy.
REQ-021 The store write (for a write) or the cpu_data_out update (for a read) SHALL occur on the same edge that busy falls.
REQ-022 Latency from the accept edge to the busy-falling edge SHALL be exactly 12 clock cycles for both reads and writes.
REQ-023 The store read for a read operation SHALL complete during CRYPT (synchronous, 1-cycle read latency).
REQ-024 cpu_data_out SHALL hold its value until the next read completes; write operations SHALL NOT change it.
REQ-025 Changes on key_in, nonce_in, cpu_addr or cpu_data_in after the accept edge SHALL have no effect on the operation in progress.

Reset
REQ-026 While rst_n=0: busy=0, cpu_data_out=0, FSM=IDLE, AES core idle.
REQ-027 Reset asserted mid-operation SHALL abort that operation with no store write and no cpu_data_out update.
REQ-028 Store contents SHALL NOT be cleared by reset.

Structure
REQ-029 A shared package SHALL hold:
- width constants (ADDR_W=8, DATA_W=128, NONCE_W=96);
- the FSM state typedef;
- the AES S-box function/table.
REQ-030 The AES-128 encryption SHALL be one sub-module, aes128_core:
- iterative, one round per cycle;
- on-the-fly key expansion;
- start/done handshake.
REQ-031 The 256x128 store SHALL be inferred block RAM inside the controller.

Verification
REQ-032 Write then read round trip:
- Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, nonce=F0F1F2F3F4F5F6F7F8F9FAFB, addr=A5, data=DEADBEEFCAFEF00D12345678ABCDEF01; after busy falls, read addr=A5.
- Required response: cpu_data_out=DEADBEEFCAFEF00D12345678ABCDEF01.
REQ-033 Store contents after the REQ-032 write:
- Required response: mem[A5] equals the plaintext XOR the golden-model AES-128(key, F0F1F2F3F4F5F6F7F8F9FAFB000000A5).
- The stored word SHALL differ from the plaintext.
REQ-034 Busy timing:
- busy=1 on the accept edge.
- busy=0 exactly 12 cycles later, for both a read and a write.
- Strobes pulsed during busy are ignored: no store change, no output change.
REQ-035 Simultaneous strobes:
- Stimulus: write_en=read_en=1 at addr 10 with data 0011...FF.
- Required response: only the write executes, cpu_data_out is unchanged, and a later read of addr 10 returns 0011...FF.
REQ-036 Reset mid-write:
- Stimulus: drive rst_n low 5 cycles after accepting a write to addr 20.
- Required response: busy=0 and cpu_data_out=0 immediately.
- The prior contents of addr 20 read back unchanged.
REQ-037 Nonce mismatch:
- Stimulus: write addr A5 with nonce N1, then read addr A5 with nonce N2≠N1.
- Required response: cpu_data_out differs from the written plaintext.
